// File: rtl/jkff_seq_pkg.sv
// Shared opcodes, FSM states and helpers for the JK bank sequencer.
// Imported by the sequencer top level and its bench.
package jkff_seq_pkg;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_UP     = 3'd3;
  localparam logic [2:0] OP_DOWN   = 3'd4;
  localparam logic [2:0] OP_TOGGLE = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_count_op(input logic [2:0] op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH behavioural JK flip-flops with async clear.
// Per bit: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_reg_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b01:   q_d[i] = 1'b0;
        2'b10:   q_d[i] = 1'b1;
        2'b11:   q_d[i] = ~q_q[i];
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

// File: rtl/jkff_bank_sequencer.sv
// Command FSM that decodes host commands into JK excitation
// for a register bank, one done pulse per command.
module jkff_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  import jkff_seq_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] up_t, dn_t;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = (cmd_op > OP_TOGGLE) ? OP_HOLD : cmd_op;
          data_d  = cmd_data;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = S_EXEC;
          cnt_d   = CNT_ONE;
          if (is_count_op(cmd_op)) begin
            cnt_d = cmd_count;
            // zero-step counts skip EXEC so the bank is untouched
            if (cmd_count == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_EXEC: begin
        cnt_d  = cnt_q - CNT_ONE;
        wrap_d = ((op_q == OP_UP) && (&q)) ||
                 ((op_q == OP_DOWN) && ~(|q));
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_HOLD;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q[i-1];
      dn_t[i] = dn_t[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    if (state_q == S_EXEC) begin
      unique case (1'b1)
        (op_q == OP_CLEAR): k = '1;
        (op_q == OP_LOAD): begin
          j = data_q;
          k = ~data_q;
        end
        (op_q == OP_TOGGLE): begin
          j = '1;
          k = '1;
        end
        (op_q == OP_UP): begin
          j = up_t;
          k = up_t;
        end
        (op_q == OP_DOWN): begin
          j = dn_t;
          k = dn_t;
        end
        default: ;
      endcase
    end
  end

  jk_reg_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk (clk),
    .rst (rst),
    .j   (j),
    .k   (k),
    .q   (q),
    .qbar(qbar)
  );

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrap      = wrap_q;

endmodule
